// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/busy/done handshake bundle for the binary-to-BCD converter
// The requester drives start/bin through master; the converter returns bcd/busy/done through slave.
interface bin_to_bcd_seq_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic                start;
   logic [WIDTH-1:0]    bin;
   logic [DIGITS*4-1:0] bcd;
   logic                busy;
   logic                done;

   modport master (output start, output bin, input bcd, input busy, input done);
   modport slave  (input start, input bin, output bcd, output busy, output done);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - iterative double-dabble binary-to-BCD converter, one bit per clock
// Optional feature: define BIN2BCD_BLANK_EN to blank leading zero digits (above digit 0) to 4'hF.
module bin_to_bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic             clk,
   input  logic             reset,
   bin_to_bcd_seq_if.slave  bus
);
   localparam int BW = DIGITS * 4;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t         state, state_next;
   logic [WIDTH-1:0] shreg, shreg_next;
   logic [BW-1:0]  scratch, scratch_next, scratch_adj;
   logic [CW-1:0]  cnt, cnt_next;
   logic [BW-1:0]  bcd_q, bcd_next, result;
   logic           busy_q, busy_next;
   logic           done_q, done_next;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = SHIFT;
         SHIFT:   if (cnt == CW'(1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Pre-shift correction: any digit >= 5 would overflow past 9 when doubled.
   always_comb begin
      scratch_adj = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[i*4 +: 4] >= 4'd5)
            scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
      end
   end

`ifdef BIN2BCD_BLANK_EN
   logic lead;
   always_comb begin
      lead   = 1'b1;
      result = scratch;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && scratch[i*4 +: 4] == 4'd0) result[i*4 +: 4] = 4'hF;
         else                                   lead = 1'b0;
      end
   end
`else
   assign result = scratch;
`endif

   // busy/done are registered, so they trail the state by one edge; done and busy fall together.
   always_comb begin
      shreg_next   = shreg;
      scratch_next = scratch;
      cnt_next     = cnt;
      bcd_next     = bcd_q;
      done_next    = 1'b0;
      busy_next    = (state != IDLE);
      case (state)
         IDLE: begin
            if (bus.start) begin
               shreg_next   = bus.bin;
               scratch_next = '0;
               cnt_next     = CW'(WIDTH);
            end
         end
         SHIFT: begin
            {scratch_next, shreg_next} = {scratch_adj, shreg} << 1;
            cnt_next = cnt - CW'(1);
         end
         DONE: begin
            bcd_next  = result;
            done_next = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '0;
         scratch <= '0;
         cnt     <= '0;
         bcd_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         shreg   <= shreg_next;
         scratch <= scratch_next;
         cnt     <= cnt_next;
         bcd_q   <= bcd_next;
         busy_q  <= busy_next;
         done_q  <= done_next;
      end
   end

   assign bus.bcd  = bcd_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed vector bench for bin_to_bcd_seq
// Expected BCD values are hand-computed; blank-build values selected when BIN2BCD_BLANK_EN is defined.
module tb_bin_to_bcd_seq;
   localparam int WIDTH  = 16;
   localparam int DIGITS = 5;
   localparam int LAT    = WIDTH + 1;

   logic clk = 1'b0;
   logic reset;

   bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();
   bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] bin;
      logic [19:0] raw;
      logic [19:0] blank;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [19:0] pick(input logic [19:0] raw, input logic [19:0] blank);
`ifdef BIN2BCD_BLANK_EN
      return blank;
`else
      return raw;
`endif
   endfunction

   // Caller is at the sample point right after the accepting edge E0.
   task automatic start_conv(input logic [15:0] v);
      bus.bin   = v;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input logic [19:0] hold, output int lat, output int busy_cnt,
                            output bit hold_ok);
      lat      = -1;
      busy_cnt = 0;
      hold_ok  = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            lat = n;
            break;
         end
         if (bus.bcd !== hold) hold_ok = 1'b0;
      end
   endtask

   initial begin
      int          lat, bc, dcnt, t1, t2, busy_seen;
      bit          hok;
      logic [19:0] prev, exp, got, got2;

      vecs[0]  = '{16'd0,     20'h00000, 20'hFFFF0};
      vecs[1]  = '{16'hFFFF,  20'h65535, 20'h65535};
      vecs[2]  = '{16'd1234,  20'h01234, 20'hF1234};
      vecs[3]  = '{16'd42,    20'h00042, 20'hFFF42};
      vecs[4]  = '{16'd999,   20'h00999, 20'hFF999};
      vecs[5]  = '{16'd9,     20'h00009, 20'hFFFF9};
      vecs[6]  = '{16'd10,    20'h00010, 20'hFFF10};
      vecs[7]  = '{16'd1,     20'h00001, 20'hFFFF1};
      vecs[8]  = '{16'd100,   20'h00100, 20'hFF100};
      vecs[9]  = '{16'd10000, 20'h10000, 20'h10000};
      vecs[10] = '{16'd9999,  20'h09999, 20'hF9999};
      vecs[11] = '{16'd7,     20'h00007, 20'hFFFF7};

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.bin   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_bcd",  32'(bus.bcd),  32'h0);
      check("reset_busy", 32'(bus.busy), 32'h0);
      check("reset_done", 32'(bus.done), 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      prev = 20'h0;
      for (int i = 0; i < 12; i++) begin
         exp = pick(vecs[i].raw, vecs[i].blank);
         start_conv(vecs[i].bin);
         bus.bin = ~vecs[i].bin;
         wait_done(prev, lat, bc, hok);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
         check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(LAT));
         check($sformatf("vec%0d_bcd", i), 32'(bus.bcd), 32'(exp));
         check($sformatf("vec%0d_bcd_hold", i), 32'(hok), 32'h1);
         @(posedge clk); #1;
         check($sformatf("vec%0d_done_fall", i), 32'(bus.done), 32'h0);
         check($sformatf("vec%0d_busy_fall", i), 32'(bus.busy), 32'h0);
         prev = exp;
      end

      // start pulses at cycles 3 and 10 of a busy conversion are dropped
      exp = pick(20'h00042, 20'hFFF42);
      start_conv(16'd42);
      dcnt = 0; lat = -1; got = '0;
      for (int n = 1; n <= 45; n++) begin
         bus.start = (n == 3 || n == 10);
         bus.bin   = bus.start ? 16'd7 : 16'd42;
         @(posedge clk); #1;
         if (bus.done) begin
            dcnt++;
            if (lat < 0) lat = n;
            got = bus.bcd;
         end
      end
      bus.start = 1'b0;
      check("busy_start_done_count", 32'(dcnt), 32'd1);
      check("busy_start_latency", 32'(lat), 32'(LAT));
      check("busy_start_bcd", 32'(got), 32'(exp));

      // reset mid-conversion while bcd holds 7
      start_conv(16'd7);
      wait_done(bus.bcd, lat, bc, hok);
      check("pre_reset_bcd", 32'(bus.bcd), 32'(pick(20'h00007, 20'hFFFF7)));
      @(posedge clk); #1;
      start_conv(16'd999);
      repeat (7) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_bcd",  32'(bus.bcd),  32'h0);
      check("abort_busy", 32'(bus.busy), 32'h0);
      check("abort_done", 32'(bus.done), 32'h0);
      dcnt = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (bus.done) dcnt++;
      end
      check("abort_no_done", 32'(dcnt), 32'h0);
      start_conv(16'd999);
      wait_done(20'h0, lat, bc, hok);
      check("after_abort_latency", 32'(lat), 32'(LAT));
      check("after_abort_bcd", 32'(bus.bcd), 32'(pick(20'h00999, 20'hFF999)));
      @(posedge clk); #1;

      // reset wins over start in the same cycle
      reset = 1'b1; bus.start = 1'b1; bus.bin = 16'd5;
      @(posedge clk); #1;
      reset = 1'b0; bus.start = 1'b0;
      dcnt = 0; busy_seen = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (bus.done) dcnt++;
         if (bus.busy) busy_seen++;
      end
      check("reset_prio_done", 32'(dcnt), 32'h0);
      check("reset_prio_busy", 32'(busy_seen), 32'h0);

      // back-to-back with start held high
      bus.bin = 16'd9; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.bin = 16'd10;
      t1 = -1; t2 = -1; got = '0; got2 = '0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            if (t1 < 0) begin
               t1 = n; got = bus.bcd;
            end else begin
               t2 = n; got2 = bus.bcd;
               bus.start = 1'b0;
               break;
            end
         end
      end
      bus.start = 1'b0;
      check("b2b_first_latency", 32'(t1), 32'(LAT));
      check("b2b_gap", 32'(t2 - t1), 32'(WIDTH + 2));
      check("b2b_first_bcd", 32'(got), 32'(pick(20'h00009, 20'hFFFF9)));
      check("b2b_second_bcd", 32'(got2), 32'(pick(20'h00010, 20'hFFF10)));
      repeat (20) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
